// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg: FSM states, status flag bit positions and control opcode shared by pio_cmd_bridge.
package pio_cmd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam int FLG_BUSY = 0;
  localparam int FLG_FULL = 1;
  localparam int FLG_OVF  = 2;
  localparam int FLG_ERR  = 3;
  localparam logic [3:0] CTRL_OPCODE = 4'hF;
endpackage

// File: rtl/pio_cmd_fifo.sv
// pio_cmd_fifo: synchronous first-word-fall-through FIFO; full/empty told apart by an extra pointer bit.
module pio_cmd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/pio_cmd_bridge.sv
// pio_cmd_bridge: queues HPS PIO instruction words and issues them one at a time to a coprocessor.
// Define PIO_CMD_BRIDGE_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module pio_cmd_bridge
  import pio_cmd_pkg::*;
#(
  parameter int INSTR_W        = 32,
  parameter int DEPTH          = 8,
  parameter int FLAG_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [INSTR_W-1:0] pio_instruct,
  input  logic               pio_enable,
  output logic [FLAG_W-1:0]  pio_flags,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [INSTR_W-1:0] cmd_data,
  input  logic               done,
  input  logic               done_err
);
  state_e state_q, state_d;
  logic enable_q;
  logic [3:0] flg_q, flg_d;
  logic [INSTR_W-1:0] head;
  logic full, empty, submit, ctrl, push, pop, ovf_set, err_set, expired;
  assign submit    = pio_enable && !enable_q;
  assign ctrl      = submit && (pio_instruct[INSTR_W-1 -: 4] == CTRL_OPCODE);
  assign pop       = (state_q == ISSUE) && cmd_ready;
  // a full queue still takes the word when the head leaves in the same cycle
  assign push      = submit && !ctrl && (!full || pop);
  assign ovf_set   = submit && !ctrl && full && !pop;
  assign cmd_valid = state_q == ISSUE;
  assign cmd_data  = cmd_valid ? head : '0;
  pio_cmd_fifo #(.W(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_clk), .rst(reset_reset), .push_i(push), .pop_i(pop),
    .data_i(pio_instruct), .head_o(head), .full_o(full), .empty_o(empty)
  );
`ifdef PIO_CMD_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;
  assign expired = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_clk) cnt_q <= (reset_reset || state_q != WAIT) ? '0 : cnt_q + 1'b1;
`else
  logic unused_timeout;
  assign expired        = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : ISSUE;
      ISSUE:   state_d = cmd_ready ? WAIT : ISSUE;
      WAIT: begin
        state_d = (done || expired) ? IDLE : WAIT;
        err_set = done ? done_err : expired;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    flg_d[FLG_BUSY] = !empty || state_q != IDLE;
    flg_d[FLG_FULL] = full;
    flg_d[FLG_OVF]  = ovf_set || (flg_q[FLG_OVF] && !ctrl);
    flg_d[FLG_ERR]  = err_set || (flg_q[FLG_ERR] && !ctrl);
    pio_flags       = '0;
    pio_flags[3:0]  = flg_q;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      flg_q    <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= pio_enable;
      flg_q    <= flg_d;
    end
  end
endmodule
